// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-bundle pipeline: branch codes, stage
// indices, the per-cycle E-stage action and the bubble encoding.
package ctrl_pipe_pkg;

    // Branch codes: 0 = no branch, then eq/slt alternate per comparator pair
    localparam int BR_NONE = 0;
    localparam int BR_EQ0  = 1;
    localparam int BR_SLT0 = 2;

    // Stage indices within ctrl_o / valid_o
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    // A bubble carries an all-zero bundle and this valid value
    localparam logic BUBBLE_VLD = 1'b0;

    // What E does this cycle (reset is handled separately, above all of these)
    typedef enum logic [1:0] {
        ACT_ADV   = 2'd0,
        ACT_FLUSH = 2'd1,
        ACT_STALL = 2'd2
    } e_act_t;

    // Busy/hold outranks flush; a flush raised while E is stalled is dropped
    function automatic e_act_t e_action(input logic busy, input logic hold, input logic flush);
        e_act_t act;
        if (busy || hold) begin
            act = ACT_STALL;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else begin
            act = ACT_ADV;
        end
        return act;
    endfunction

endpackage

// File: rtl/ex_latency_counter.sv
// Counts the extra execute cycles of the op sitting in E. Loads the op's
// latency when it enters E, otherwise counts down to zero.
module ex_latency_counter #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [LAT_W-1:0] load_val,
    output logic             busy_o
);

    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] cnt_q;

    // Next count: decrement while busy, else load on entry, else idle at zero
    always_comb begin
        cnt_d = {LAT_W{1'b0}};
        if (cnt_q != {LAT_W{1'b0}}) begin
            cnt_d = cnt_q - LAT_W'(1);
        end else if (load_en) begin
            cnt_d = load_val;
        end else begin
            cnt_d = {LAT_W{1'b0}};
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {LAT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != {LAT_W{1'b0}});

endmodule

// File: rtl/ctrl_pipe_stage_chain.sv
// Control-bundle pipeline from D through NSTAGE registered stages with flush,
// external hold and multi-cycle execute stall, plus D-stage branch resolution.
module ctrl_pipe_stage_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 32,
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned LAT_W  = 3,
    parameter int unsigned NCMP   = 2,
    parameter int unsigned BR_W   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CTRL_W-1:0]        ctrl_d,
    input  logic                     valid_d,
    input  logic [LAT_W-1:0]         lat_d,
    input  logic                     flush_e,
    input  logic                     hold_e,
    input  logic [BR_W-1:0]          branch_d,
    input  logic [NCMP-1:0]          cmp_eq,
    input  logic [NCMP-1:0]          cmp_slt,
    output logic [NSTAGE*CTRL_W-1:0] ctrl_o,
    output logic [NSTAGE-1:0]        valid_o,
    output logic                     stall_o,
    output logic                     pcsrc_d
);

    // Branch mux: code c selects cmp_eq[k] (odd c) or cmp_slt[k] (even c), k=(c-1)>>1
    function automatic logic branch_sel(input logic [BR_W-1:0] code,
                                        input logic [NCMP-1:0] eq,
                                        input logic [NCMP-1:0] slt);
        logic taken;
        taken = 1'b0;
        for (int k = 0; k < int'(NCMP); k++) begin
            if (code == BR_W'(BR_EQ0 + 2 * k)) begin
                taken = eq[k];
            end else if (code == BR_W'(BR_SLT0 + 2 * k)) begin
                taken = slt[k];
            end else begin
                taken = taken;
            end
        end
        if (code == BR_W'(BR_NONE)) begin
            taken = 1'b0;
        end else begin
            taken = taken;
        end
        return taken;
    endfunction

    logic [NSTAGE-1:0][CTRL_W-1:0] stg_ctrl_d;
    logic [NSTAGE-1:0][CTRL_W-1:0] stg_ctrl_q;
    logic [NSTAGE-1:0]             stg_vld_d;
    logic [NSTAGE-1:0]             stg_vld_q;
    logic                          busy_s;
    logic                          load_en_s;
    e_act_t                        act_s;

    // Decide this cycle's E action and whether a real op enters E
    always_comb begin
        act_s     = e_action(busy_s, hold_e, flush_e);
        load_en_s = 1'b0;
        if (act_s == ACT_ADV) begin
            load_en_s = valid_d;
        end else begin
            load_en_s = 1'b0;
        end
    end

    ex_latency_counter #(
        .LAT_W (LAT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en_s),
        .load_val (lat_d),
        .busy_o   (busy_s)
    );

    for (genvar i = 0; i < int'(NSTAGE); i++) begin : g_stage
        if (i == STG_E) begin : g_e
            // E: keep while stalled, bubble on flush, otherwise take the D bundle
            always_comb begin
                stg_ctrl_d[i] = stg_ctrl_q[i];
                stg_vld_d[i]  = stg_vld_q[i];
                case (act_s)
                    ACT_STALL: begin
                        stg_ctrl_d[i] = stg_ctrl_q[i];
                        stg_vld_d[i]  = stg_vld_q[i];
                    end
                    ACT_FLUSH: begin
                        stg_ctrl_d[i] = {CTRL_W{1'b0}};
                        stg_vld_d[i]  = BUBBLE_VLD;
                    end
                    ACT_ADV: begin
                        stg_ctrl_d[i] = ctrl_d;
                        stg_vld_d[i]  = valid_d;
                    end
                    default: begin
                        stg_ctrl_d[i] = {CTRL_W{1'b0}};
                        stg_vld_d[i]  = BUBBLE_VLD;
                    end
                endcase
            end
        end else if (i == STG_M) begin : g_m
            // M: bubble while E is stalled, otherwise take E
            always_comb begin
                stg_ctrl_d[i] = stg_ctrl_q[i-1];
                stg_vld_d[i]  = stg_vld_q[i-1];
                if (act_s == ACT_STALL) begin
                    stg_ctrl_d[i] = {CTRL_W{1'b0}};
                    stg_vld_d[i]  = BUBBLE_VLD;
                end else begin
                    stg_ctrl_d[i] = stg_ctrl_q[i-1];
                    stg_vld_d[i]  = stg_vld_q[i-1];
                end
            end
        end else begin : g_late
            // W and later: always advance from the previous stage
            always_comb begin
                stg_ctrl_d[i] = stg_ctrl_q[i-1];
                stg_vld_d[i]  = stg_vld_q[i-1];
            end
        end

        // Stage register with synchronous reset to a bubble
        always_ff @(posedge clk) begin
            if (reset) begin
                stg_ctrl_q[i] <= {CTRL_W{1'b0}};
                stg_vld_q[i]  <= BUBBLE_VLD;
            end else begin
                stg_ctrl_q[i] <= stg_ctrl_d[i];
                stg_vld_q[i]  <= stg_vld_d[i];
            end
        end
    end

    assign ctrl_o  = stg_ctrl_q;
    assign valid_o = stg_vld_q;
    assign stall_o = !reset && (busy_s || hold_e);
    assign pcsrc_d = branch_sel(branch_d, cmp_eq, cmp_slt);

endmodule

// File: tb/tb_ctrl_pipe_stage_chain.sv
// Randomised and directed bench for ctrl_pipe_stage_chain against a
// cycle-level behavioural model of the pipeline rules.
module tb_ctrl_pipe_stage_chain;

    localparam int CTRL_W = 32;
    localparam int NSTAGE = 3;
    localparam int LAT_W  = 3;
    localparam int NCMP   = 2;
    localparam int BR_W   = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [CTRL_W-1:0]        ctrl_d;
    logic                     valid_d;
    logic [LAT_W-1:0]         lat_d;
    logic                     flush_e;
    logic                     hold_e;
    logic [BR_W-1:0]          branch_d;
    logic [NCMP-1:0]          cmp_eq;
    logic [NCMP-1:0]          cmp_slt;
    logic [NSTAGE*CTRL_W-1:0] ctrl_o;
    logic [NSTAGE-1:0]        valid_o;
    logic                     stall_o;
    logic                     pcsrc_d;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [CTRL_W-1:0] m_ctrl [NSTAGE];
    logic              m_vld  [NSTAGE];
    int                m_cnt;

    always #5 clk = ~clk;

    ctrl_pipe_stage_chain #(
        .CTRL_W (CTRL_W), .NSTAGE (NSTAGE), .LAT_W (LAT_W), .NCMP (NCMP), .BR_W (BR_W)
    ) dut (
        .clk (clk), .reset (reset), .ctrl_d (ctrl_d), .valid_d (valid_d), .lat_d (lat_d),
        .flush_e (flush_e), .hold_e (hold_e), .branch_d (branch_d), .cmp_eq (cmp_eq),
        .cmp_slt (cmp_slt), .ctrl_o (ctrl_o), .valid_o (valid_o), .stall_o (stall_o),
        .pcsrc_d (pcsrc_d)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_branch(input int code, input logic [NCMP-1:0] eq,
                                        input logic [NCMP-1:0] slt);
        int k;
        if (code == 0 || code > 2 * NCMP) return 1'b0;
        k = (code - 1) / 2;
        if (code % 2 == 1) return eq[k];
        return slt[k];
    endfunction

    function automatic logic [NSTAGE*CTRL_W-1:0] m_ctrl_flat();
        logic [NSTAGE*CTRL_W-1:0] r;
        for (int i = 0; i < NSTAGE; i++) r[i*CTRL_W +: CTRL_W] = m_ctrl[i];
        return r;
    endfunction

    function automatic logic [NSTAGE-1:0] m_vld_flat();
        logic [NSTAGE-1:0] r;
        for (int i = 0; i < NSTAGE; i++) r[i] = m_vld[i];
        return r;
    endfunction

    // one clock edge of the pipeline rules, using the inputs currently applied
    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < NSTAGE; i++) begin m_ctrl[i] = '0; m_vld[i] = 1'b0; end
            m_cnt = 0;
        end else begin
            for (int i = NSTAGE - 1; i >= 1; i--) begin
                m_ctrl[i] = m_ctrl[i-1];
                m_vld[i]  = m_vld[i-1];
            end
            if (m_cnt != 0 || hold_e) begin
                m_ctrl[1] = '0;
                m_vld[1]  = 1'b0;
                if (m_cnt != 0) m_cnt = m_cnt - 1;
            end else if (flush_e) begin
                m_ctrl[0] = '0;
                m_vld[0]  = 1'b0;
                m_cnt     = 0;
            end else begin
                m_ctrl[0] = ctrl_d;
                m_vld[0]  = valid_d;
                m_cnt     = valid_d ? int'(lat_d) : 0;
            end
        end
    endtask

    // apply current inputs for one cycle: check combinational outputs, clock, check state
    task automatic step();
        #1;
        check_eq("stall", stall_o, !reset && (m_cnt != 0 || hold_e));
        check_eq("pcsrc", pcsrc_d, ref_branch(int'(branch_d), cmp_eq, cmp_slt));
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_eq("ctrl", ctrl_o, m_ctrl_flat());
        check_eq("valid", valid_o, m_vld_flat());
    endtask

    task automatic idle_in();
        ctrl_d = '0; valid_d = 1'b0; lat_d = '0; flush_e = 1'b0; hold_e = 1'b0;
        branch_d = '0; cmp_eq = '0; cmp_slt = '0;
    endtask

    task automatic put(input logic [CTRL_W-1:0] c, input logic [LAT_W-1:0] l);
        ctrl_d = c; valid_d = 1'b1; lat_d = l;
    endtask

    initial begin
        logic [BR_W-1:0] br_code [6];
        logic            br_exp  [6];
        for (int i = 0; i < NSTAGE; i++) begin m_ctrl[i] = '0; m_vld[i] = 1'b0; end
        m_cnt = 0;
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        step(); step();
        check_eq("rst_valid", valid_o, '0);
        check_eq("rst_ctrl", ctrl_o, '0);
        reset = 1'b0;

        // plain stream reaches W three edges after acceptance
        put(32'h11, 3'd0); step();
        put(32'h22, 3'd0); step();
        put(32'h33, 3'd0); step();
        check_eq("t1_w11", ctrl_o[2*CTRL_W +: CTRL_W], 32'h11);
        idle_in(); step();
        check_eq("t1_w22", ctrl_o[2*CTRL_W +: CTRL_W], 32'h22);
        step();
        check_eq("t1_w33", ctrl_o[2*CTRL_W +: CTRL_W], 32'h33);
        step(); step();

        // two-cycle latency op
        put(32'hA5, 3'd2); step();
        check_eq("t2_stall", stall_o, 1'b1);
        put(32'h5A, 3'd0); step();
        check_eq("t2_mbub", valid_o[1], 1'b0);
        step();
        check_eq("t2_e_hold", ctrl_o[0 +: CTRL_W], 32'hA5);
        step();
        check_eq("t2_e_next", ctrl_o[0 +: CTRL_W], 32'h5A);
        check_eq("t2_m_a5", ctrl_o[CTRL_W +: CTRL_W], 32'hA5);
        idle_in(); step(); step(); step();

        // reset while busy
        put(32'h77, 3'd3); step();
        idle_in(); step();
        reset = 1'b1; step();
        check_eq("t3_valid", valid_o, '0);
        check_eq("t3_ctrl", ctrl_o, '0);
        check_eq("t3_stall", stall_o, 1'b0);
        reset = 1'b0;

        // flush ignored while busy, honoured once idle
        put(32'h44, 3'd1); step();
        put(32'h55, 3'd0); flush_e = 1'b1; step();
        check_eq("t4_keep", ctrl_o[0 +: CTRL_W], 32'h44);
        step();
        check_eq("t4_ebub", valid_o[0], 1'b0);
        check_eq("t4_m44", ctrl_o[CTRL_W +: CTRL_W], 32'h44);
        idle_in(); step(); step();

        // single-cycle hold
        put(32'h61, 3'd0); step();
        put(32'h62, 3'd0); step();
        put(32'h63, 3'd0); hold_e = 1'b1; step();
        check_eq("t5_e", ctrl_o[0 +: CTRL_W], 32'h62);
        check_eq("t5_mbub", valid_o[1], 1'b0);
        check_eq("t5_w", ctrl_o[2*CTRL_W +: CTRL_W], 32'h61);
        hold_e = 1'b0; step();
        idle_in(); step(); step();

        // branch table
        br_code = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0};
        br_exp  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        cmp_eq = 2'b11; cmp_slt = 2'b10;
        for (int i = 0; i < 6; i++) begin
            branch_d = br_code[i];
            #1;
            check_eq($sformatf("br_code%0d", i), pcsrc_d, br_exp[i]);
            step();
        end
        cmp_eq = 2'b00; cmp_slt = 2'b01; branch_d = 3'd2;
        #1 check_eq("br_slt0", pcsrc_d, 1'b1);
        step();
        idle_in();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 40) == 0);
            ctrl_d   = $urandom;
            valid_d  = ($urandom_range(0, 3) != 0);
            lat_d    = ($urandom_range(0, 3) == 0) ? LAT_W'($urandom_range(1, 7)) : '0;
            flush_e  = ($urandom_range(0, 5) == 0);
            hold_e   = ($urandom_range(0, 5) == 0);
            branch_d = BR_W'($urandom_range(0, 7));
            cmp_eq   = NCMP'($urandom_range(0, 3));
            cmp_slt  = NCMP'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
